// File: rtl/conv1_pixel_streamer_pkg.sv
// Shared constants and state type for the conv layer 1 pixel interface.
// The image geometry here also sizes the conv_layer_1 line buffers.
package conv1_pkg;

    localparam int IMG_W      = 28;
    localparam int IMG_H      = 28;
    localparam int PIX_W      = 8;
    localparam int IMG_PIXELS = IMG_W * IMG_H;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } stream_state_e;

    // A frame is in progress while reads are issued or still in flight.
    function automatic logic in_frame(input stream_state_e st);
        return (st == STREAM) || (st == DRAIN);
    endfunction

endpackage

// File: rtl/conv1_pixel_streamer_valid_pipe.sv
// DEPTH-stage 1-bit shift register with synchronous clear; tracks which
// cycles of a synchronous RAM's output carry requested data.
module streamer_valid_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic clr_i,
    input  logic d_i,
    output logic tail_o,
    output logic empty_o
);

    logic [DEPTH-1:0] shift_q;
    logic [DEPTH-1:0] shift_d;

    // Next-state: shift one stage towards the tail.
    always_comb begin
        shift_d[0] = d_i;
        for (int i = 1; i < DEPTH; i++) begin
            shift_d[i] = shift_q[i-1];
        end
    end

    // Stage registers.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign tail_o  = shift_q[DEPTH-1];
    assign empty_o = ~(|shift_q);

endmodule

// File: rtl/conv1_pixel_streamer.sv
// Reads one image from a synchronous RAM in raster order and streams it as
// pixel/valid into conv_layer_1, one frame per start strobe.
module conv1_pixel_streamer #(
    parameter int WIDTH   = conv1_pkg::IMG_W,
    parameter int HEIGHT  = conv1_pkg::IMG_H,
    parameter int PIX_W   = conv1_pkg::PIX_W,
    parameter int RAM_LAT = 1,
    parameter int ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    output logic              img_rd_en,
    output logic [ADDR_W-1:0] img_addr,
    input  logic [PIX_W-1:0]  img_rd_data,
    output logic [PIX_W-1:0]  pixel_out,
    output logic              valid_out,
    output logic              busy,
    output logic              done
);
    import conv1_pkg::*;

    localparam int                NPIX      = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    stream_state_e      state_q, state_d;
    logic [ADDR_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [PIX_W-1:0]   pixel_q, pixel_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rd_en_s;
    logic               pipe_tail_s;
    logic               pipe_empty_s;

    // Frame sequencing and read issue.
    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        rd_en_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = STREAM;
                    rd_cnt_d = '0;
                end else begin
                    state_d  = IDLE;
                end
            end
            STREAM: begin
                rd_en_s = ~pause;
                if (rd_en_s) begin
                    rd_cnt_d = rd_cnt_q + ADDR_W'(1);
                    if (rd_cnt_q == LAST_ADDR) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = STREAM;
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q;
                end
            end
            // Once the pipe is empty, the final pixel is on valid_out.
            DRAIN: begin
                if (pipe_empty_s) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register next-state; status flags follow the next state so
    // they line up with the state itself.
    always_comb begin
        valid_d = pipe_tail_s;
        if (pipe_tail_s) begin
            pixel_d = img_rd_data;
        end else begin
            pixel_d = pixel_q;
        end
        busy_d = in_frame(state_d);
        done_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rd_cnt_q <= '0;
            pixel_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            pixel_q  <= pixel_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    streamer_valid_pipe #(
        .DEPTH (RAM_LAT)
    ) u_valid_pipe (
        .clk     (clk),
        .clr_i   (rst),
        .d_i     (rd_en_s),
        .tail_o  (pipe_tail_s),
        .empty_o (pipe_empty_s)
    );

    assign img_rd_en = rd_en_s;
    assign img_addr  = rd_en_s ? rd_cnt_q : '0;
    assign pixel_out = pixel_q;
    assign valid_out = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
